// File: rtl/pattern_reader.sv
// Avalon-MM burst read master: fetches a byte range in bursts and streams the words out with EOP.
// Define PATTERN_READER_BURST_REALIGN_EN to keep bursts from crossing MAX_BURST_COUNT-word boundaries.
`timescale 1ns/1ps

module pattern_reader #(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int LENGTH_WIDTH      = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int MAX_BURST_COUNT   = 2,
    parameter int BURST_WIDTH       = 2,
    parameter int FIFO_DEPTH        = 128,
    parameter int FIFO_DEPTH_LOG2   = 7
) (
    input  logic                         clk,
    input  logic                         reset_n,
    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_read,
    output logic [BURST_WIDTH-1:0]       master_burstcount,
    output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
    input  logic                         master_waitrequest,
    input  logic [DATA_WIDTH-1:0]        master_readdata,
    input  logic                         master_readdatavalid,
    output logic [DATA_WIDTH-1:0]        src_data,
    output logic                         src_valid,
    input  logic                         src_ready,
    output logic                         src_endofpacket,
    input  logic [95:0]                  snk_command_data,
    input  logic                         snk_command_valid,
    output logic                         snk_command_ready,
    output logic                         done
);

    localparam int BE_LOG2 = $clog2(BYTE_ENABLE_WIDTH);
    localparam int CNT_W   = FIFO_DEPTH_LOG2 + 1;
    localparam int SPACE_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                     state_q;
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic [LENGTH_WIDTH-1:0]    remain_q;
    logic [LENGTH_WIDTH-1:0]    streamLeft_q;
    logic [BURST_WIDTH-1:0]     burst_q;
    logic                       read_q;
    logic                       ready_q;
    logic                       done_q;
    logic [CNT_W-1:0]           used_q;
    logic [CNT_W-1:0]           pending_q;
    logic [FIFO_DEPTH_LOG2-1:0] wrPtr_q;
    logic [FIFO_DEPTH_LOG2-1:0] rdPtr_q;
    logic [DATA_WIDTH-1:0]      fifoMem_q [FIFO_DEPTH];

    logic [LENGTH_WIDTH-1:0]    cmdWords;
    logic [ADDRESS_WIDTH-1:0]   cmdAddr;
    logic                       acceptBurst;
    logic                       pushWord;
    logic                       popWord;
    logic [CNT_W-1:0]           used_d;
    logic [CNT_W-1:0]           pending_d;
    logic [LENGTH_WIDTH-1:0]    streamLeft_d;
    logic [LENGTH_WIDTH-1:0]    remain_d;
    logic [ADDRESS_WIDTH-1:0]   addr_d;
    logic [BURST_WIDTH-1:0]     firstBurst;
    logic [BURST_WIDTH-1:0]     nextBurst;
    logic [SPACE_W-1:0]         space_d;
    logic                       roomOk;
    logic                       unused_cmd;

`ifdef PATTERN_READER_BURST_REALIGN_EN
    function automatic logic [BURST_WIDTH-1:0] calcBurst(input logic [LENGTH_WIDTH-1:0]  words,
                                                          input logic [ADDRESS_WIDTH-1:0] addr);
        logic [LENGTH_WIDTH-1:0] limit;
        limit = LENGTH_WIDTH'(MAX_BURST_COUNT)
              - LENGTH_WIDTH'((addr >> BE_LOG2) & ADDRESS_WIDTH'(MAX_BURST_COUNT - 1));
        if (words < limit) limit = words;
        return BURST_WIDTH'(limit);
    endfunction
`else
    function automatic logic [BURST_WIDTH-1:0] calcBurst(input logic [LENGTH_WIDTH-1:0] words);
        if (words < LENGTH_WIDTH'(MAX_BURST_COUNT)) return BURST_WIDTH'(words);
        return BURST_WIDTH'(MAX_BURST_COUNT);
    endfunction
`endif

    assign cmdWords     = LENGTH_WIDTH'(snk_command_data[95:64] >> BE_LOG2);
    assign cmdAddr      = ADDRESS_WIDTH'(snk_command_data[63:32]);
    assign unused_cmd   = ^snk_command_data[31:0];

    assign acceptBurst  = read_q & ~master_waitrequest;
    assign pushWord     = master_readdatavalid & (pending_q != '0);
    assign popWord      = src_valid & src_ready;
    assign used_d       = used_q + CNT_W'(pushWord) - CNT_W'(popWord);
    assign pending_d    = pending_q + (acceptBurst ? CNT_W'(burst_q) : '0) - CNT_W'(pushWord);
    assign streamLeft_d = streamLeft_q - LENGTH_WIDTH'(popWord);
    assign remain_d     = remain_q - (acceptBurst ? LENGTH_WIDTH'(burst_q) : '0);
    assign addr_d       = addr_q + (acceptBurst ? (ADDRESS_WIDTH'(burst_q) << BE_LOG2) : '0);

`ifdef PATTERN_READER_BURST_REALIGN_EN
    assign firstBurst   = calcBurst(cmdWords, cmdAddr);
    assign nextBurst    = calcBurst(remain_d, addr_d);
`else
    assign firstBurst   = calcBurst(cmdWords);
    assign nextBurst    = calcBurst(remain_d);
`endif

    // Room is judged on next-cycle occupancy so outstanding reads can never overflow the FIFO.
    assign space_d      = SPACE_W'(FIFO_DEPTH) - SPACE_W'(used_d) - SPACE_W'(pending_d);
    assign roomOk       = space_d >= SPACE_W'(nextBurst);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            streamLeft_q <= '0;
            burst_q      <= '0;
            read_q       <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            used_q       <= '0;
            pending_q    <= '0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
        end else begin
            done_q       <= 1'b0;
            used_q       <= used_d;
            pending_q    <= pending_d;
            streamLeft_q <= streamLeft_d;
            if (pushWord) wrPtr_q <= wrPtr_q + 1'b1;
            if (popWord)  rdPtr_q <= rdPtr_q + 1'b1;

            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (snk_command_valid && ready_q) begin
                        ready_q      <= 1'b0;
                        addr_q       <= cmdAddr;
                        streamLeft_q <= cmdWords;
                        if (cmdWords == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            remain_q <= cmdWords;
                            burst_q  <= firstBurst;
                            read_q   <= 1'b1;
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!(read_q && master_waitrequest)) begin
                        addr_q   <= addr_d;
                        remain_q <= remain_d;
                        if (remain_d == '0) begin
                            read_q  <= 1'b0;
                            state_q <= DRAIN;
                        end else begin
                            burst_q <= nextBurst;
                            read_q  <= roomOk;
                        end
                    end
                end
                DRAIN: begin
                    if (pending_d == '0 && streamLeft_d == '0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pushWord) fifoMem_q[wrPtr_q] <= master_readdata;
    end

    assign master_address    = addr_q;
    assign master_read       = read_q;
    assign master_burstcount = burst_q;
    assign master_byteenable = {BYTE_ENABLE_WIDTH{read_q}};
    assign src_valid         = used_q != '0;
    assign src_data          = src_valid ? fifoMem_q[rdPtr_q] : '0;
    assign src_endofpacket   = src_valid && (streamLeft_q == LENGTH_WIDTH'(1));
    assign snk_command_ready = ready_q;
    assign done              = done_q;

endmodule

// File: tb/tb_pattern_reader.sv
// Directed testbench for pattern_reader: memory slave model returns the word byte address as data.
`timescale 1ns/1ps

module tb_pattern_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] master_address;
    logic        master_read;
    logic [1:0]  master_burstcount;
    logic [3:0]  master_byteenable;
    logic        master_waitrequest;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        src_endofpacket;
    logic [95:0] snk_command_data;
    logic        snk_command_valid;
    logic        snk_command_ready;
    logic        done;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    logic [31:0] burstAddr[$];
    int          burstCnt[$];
    logic [31:0] beatData[$];
    logic        beatEop[$];
    logic [31:0] respQ[$];

    pattern_reader dut (
        .clk(clk), .reset_n(reset_n),
        .master_address(master_address), .master_read(master_read),
        .master_burstcount(master_burstcount), .master_byteenable(master_byteenable),
        .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_endofpacket(src_endofpacket),
        .snk_command_data(snk_command_data), .snk_command_valid(snk_command_valid),
        .snk_command_ready(snk_command_ready), .done(done)
    );

    always #5 clk = ~clk;

    // Handshakes are observed mid-cycle, where they hold the values the next rising edge will use.
    always @(negedge clk) begin
        if (reset_n) begin
            if (master_read && !master_waitrequest) begin
                burstAddr.push_back(master_address);
                burstCnt.push_back(int'(master_burstcount));
                for (int i = 0; i < int'(master_burstcount); i++)
                    respQ.push_back(master_address + 32'(4 * i));
            end
            if (src_valid && src_ready) begin
                beatData.push_back(src_data);
                beatEop.push_back(src_endofpacket);
            end
            if (done) doneCount++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            respQ.delete();
            master_readdatavalid = 1'b0;
        end else if (respQ.size() > 0) begin
            master_readdatavalid = 1'b1;
            master_readdata      = respQ.pop_front();
        end else begin
            master_readdatavalid = 1'b0;
        end
    end

    task automatic clearLogs();
        burstAddr.delete();
        burstCnt.delete();
        beatData.delete();
        beatEop.delete();
        doneCount = 0;
    endtask

    task automatic sendCommand(input logic [31:0] len, input logic [31:0] addr);
        int n = 0;
        @(posedge clk); #1;
        while (!snk_command_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!snk_command_ready) begin
            errors++;
            $display("[TB] FAIL cmd_ready_timeout: ready=%0b, expected 1", snk_command_ready);
        end
        snk_command_data  = {len, addr, 32'h0};
        snk_command_valid = 1'b1;
        @(posedge clk); #1;
        snk_command_valid = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget, input string name);
        int n = 0;
        while (doneCount < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (doneCount < target) begin
            errors++;
            $display("[TB] FAIL %s_done_timeout: done count %0d, expected %0d", name, doneCount, target);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        master_waitrequest = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata = '0;
        src_ready = 1'b1;
        snk_command_valid = 1'b0;
        snk_command_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (master_read !== 1'b0) begin errors++; $display("[TB] FAIL rst_read: got %0b, expected 0", master_read); end
        if (master_byteenable !== 4'h0) begin errors++; $display("[TB] FAIL rst_be: got %h, expected 0", master_byteenable); end
        if (src_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_src_valid: got %0b, expected 0", src_valid); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %0b, expected 0", done); end
        if (snk_command_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %0b, expected 0", snk_command_ready); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (snk_command_ready !== 1'b0) begin errors++; $display("[TB] FAIL rel_ready_early: got %0b, expected 0", snk_command_ready); end
        @(posedge clk); #1;
        checks++;
        if (snk_command_ready !== 1'b1) begin errors++; $display("[TB] FAIL rel_ready: got %0b, expected 1", snk_command_ready); end
    endtask

    task automatic test_full_stream();
        clearLogs();
        sendCommand(32'd1024, 32'h0);
        waitDone(1, 2000, "full");
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (burstAddr.size() !== 128) begin errors++; $display("[TB] FAIL full_bursts: got %0d, expected 128", burstAddr.size()); end
        if (beatData.size() !== 256) begin errors++; $display("[TB] FAIL full_beats: got %0d, expected 256", beatData.size()); end
        if (doneCount !== 1) begin errors++; $display("[TB] FAIL full_done_count: got %0d, expected 1", doneCount); end
        if (snk_command_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_after: got %0b, expected 1", snk_command_ready); end
        for (int i = 0; i < burstAddr.size() && i < 128; i++) begin
            checks++;
            if (burstAddr[i] !== 32'(8 * i) || burstCnt[i] !== 2) begin
                errors++;
                $display("[TB] FAIL full_burst[%0d]: got addr %h cnt %0d, expected addr %h cnt 2", i, burstAddr[i], burstCnt[i], 32'(8 * i));
            end
        end
        for (int i = 0; i < beatData.size() && i < 256; i++) begin
            checks++;
            if (beatData[i] !== 32'(4 * i) || beatEop[i] !== (i == 255)) begin
                errors++;
                $display("[TB] FAIL full_beat[%0d]: got data %h eop %0b, expected data %h eop %0b", i, beatData[i], beatEop[i], 32'(4 * i), (i == 255));
            end
        end
    endtask

    task automatic test_zero_length();
        clearLogs();
        sendCommand(32'd0, 32'h100);
        @(negedge clk);
        checks += 2;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done_pulse: got %0b, expected 1", done); end
        if (snk_command_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_ready_low: got %0b, expected 0", snk_command_ready); end
        repeat (10) @(posedge clk);
        #1;
        checks += 4;
        if (burstAddr.size() !== 0) begin errors++; $display("[TB] FAIL zero_bursts: got %0d, expected 0", burstAddr.size()); end
        if (beatData.size() !== 0) begin errors++; $display("[TB] FAIL zero_beats: got %0d, expected 0", beatData.size()); end
        if (doneCount !== 1) begin errors++; $display("[TB] FAIL zero_done_count: got %0d, expected 1", doneCount); end
        if (snk_command_ready !== 1'b1) begin errors++; $display("[TB] FAIL zero_ready_after: got %0b, expected 1", snk_command_ready); end
    endtask

    task automatic test_waitrequest();
        clearLogs();
        master_waitrequest = 1'b1;
        sendCommand(32'd12, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (master_read !== 1'b1 || master_address !== 32'h0 || master_burstcount !== 2'd2) begin
                errors++;
                $display("[TB] FAIL wait_hold[%0d]: got read %0b addr %h cnt %0d, expected read 1 addr 0 cnt 2", c, master_read, master_address, master_burstcount);
            end
        end
        @(posedge clk); #1;
        master_waitrequest = 1'b0;
        waitDone(1, 200, "wait");
        checks += 2;
        if (burstAddr.size() !== 2) begin errors++; $display("[TB] FAIL wait_bursts: got %0d, expected 2", burstAddr.size()); end
        if (beatData.size() !== 3) begin errors++; $display("[TB] FAIL wait_beats: got %0d, expected 3", beatData.size()); end
        if (burstAddr.size() == 2) begin
            checks++;
            if (burstAddr[0] !== 32'h0 || burstCnt[0] !== 2 || burstAddr[1] !== 32'h8 || burstCnt[1] !== 1) begin
                errors++;
                $display("[TB] FAIL wait_burst_list: got (%h,%0d),(%h,%0d), expected (0,2),(8,1)", burstAddr[0], burstCnt[0], burstAddr[1], burstCnt[1]);
            end
        end
        for (int i = 0; i < beatData.size() && i < 3; i++) begin
            checks++;
            if (beatData[i] !== 32'(4 * i) || beatEop[i] !== (i == 2)) begin
                errors++;
                $display("[TB] FAIL wait_beat[%0d]: got data %h eop %0b, expected data %h eop %0b", i, beatData[i], beatEop[i], 32'(4 * i), (i == 2));
            end
        end
    endtask

    task automatic test_backpressure();
        int words = 0;
        clearLogs();
        src_ready = 1'b0;
        sendCommand(32'd2048, 32'h1000);
        repeat (400) @(posedge clk);
        #1;
        foreach (burstCnt[i]) words += burstCnt[i];
        checks += 3;
        if (words !== 128) begin errors++; $display("[TB] FAIL bp_words_in_flight: got %0d, expected 128", words); end
        if (beatData.size() !== 0) begin errors++; $display("[TB] FAIL bp_beats_stalled: got %0d, expected 0", beatData.size()); end
        if (master_read !== 1'b0) begin errors++; $display("[TB] FAIL bp_read_stopped: got %0b, expected 0", master_read); end
        src_ready = 1'b1;
        waitDone(1, 3000, "bp");
        words = 0;
        foreach (burstCnt[i]) words += burstCnt[i];
        checks += 2;
        if (words !== 512) begin errors++; $display("[TB] FAIL bp_words_total: got %0d, expected 512", words); end
        if (beatData.size() !== 512) begin errors++; $display("[TB] FAIL bp_beats: got %0d, expected 512", beatData.size()); end
        for (int i = 0; i < beatData.size() && i < 512; i++) begin
            checks++;
            if (beatData[i] !== 32'h1000 + 32'(4 * i) || beatEop[i] !== (i == 511)) begin
                errors++;
                $display("[TB] FAIL bp_beat[%0d]: got data %h eop %0b, expected data %h eop %0b", i, beatData[i], beatEop[i], 32'h1000 + 32'(4 * i), (i == 511));
            end
        end
    endtask

    task automatic test_alignment();
        logic [31:0] expAddr[$];
        int          expCnt[$];
`ifdef PATTERN_READER_BURST_REALIGN_EN
        expAddr = '{32'h4, 32'h8, 32'h10};
        expCnt  = '{1, 2, 1};
`else
        expAddr = '{32'h4, 32'hC};
        expCnt  = '{2, 2};
`endif
        clearLogs();
        sendCommand(32'd16, 32'h4);
        waitDone(1, 200, "align");
        checks += 2;
        if (burstAddr.size() !== expAddr.size()) begin errors++; $display("[TB] FAIL align_bursts: got %0d, expected %0d", burstAddr.size(), expAddr.size()); end
        if (beatData.size() !== 4) begin errors++; $display("[TB] FAIL align_beats: got %0d, expected 4", beatData.size()); end
        for (int i = 0; i < burstAddr.size() && i < expAddr.size(); i++) begin
            checks++;
            if (burstAddr[i] !== expAddr[i] || burstCnt[i] !== expCnt[i]) begin
                errors++;
                $display("[TB] FAIL align_burst[%0d]: got addr %h cnt %0d, expected addr %h cnt %0d", i, burstAddr[i], burstCnt[i], expAddr[i], expCnt[i]);
            end
        end
        for (int i = 0; i < beatData.size() && i < 4; i++) begin
            checks++;
            if (beatData[i] !== 32'h4 + 32'(4 * i) || beatEop[i] !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL align_beat[%0d]: got data %h eop %0b, expected data %h eop %0b", i, beatData[i], beatEop[i], 32'h4 + 32'(4 * i), (i == 3));
            end
        end
    endtask

    task automatic test_reset_midissue();
        int n = 0;
        clearLogs();
        sendCommand(32'd1024, 32'h0);
        while (burstAddr.size() < 5 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (master_read !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_read: got %0b, expected 0", master_read); end
        if (src_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_src_valid: got %0b, expected 0", src_valid); end
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_done: got %0b, expected 0", done); end
        if (snk_command_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ready: got %0b, expected 0", snk_command_ready); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clearLogs();
        sendCommand(32'd32, 32'h200);
        waitDone(1, 300, "mid");
        repeat (3) @(posedge clk);
        checks += 3;
        if (burstAddr.size() !== 4) begin errors++; $display("[TB] FAIL mid_bursts: got %0d, expected 4", burstAddr.size()); end
        if (beatData.size() !== 8) begin errors++; $display("[TB] FAIL mid_beats: got %0d, expected 8", beatData.size()); end
        if (doneCount !== 1) begin errors++; $display("[TB] FAIL mid_done_count: got %0d, expected 1", doneCount); end
        for (int i = 0; i < beatData.size() && i < 8; i++) begin
            checks++;
            if (beatData[i] !== 32'h200 + 32'(4 * i) || beatEop[i] !== (i == 7)) begin
                errors++;
                $display("[TB] FAIL mid_beat[%0d]: got data %h eop %0b, expected data %h eop %0b", i, beatData[i], beatEop[i], 32'h200 + 32'(4 * i), (i == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_zero_length();
        test_waitrequest();
        test_backpressure();
        test_alignment();
        test_reset_midissue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
